clt_normal_gen: RTL



---
 rtl/clt_normal_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/clt_normal_gen.sv
// Central-limit normal approximator: sums N_SUM uniform samples and removes the mean.
// Optional output saturation to +/-CLAMP_LIM is compiled in with `define CLT_CLAMP_EN.
module clt_normal_gen #(
    parameter int IN_W      = 32,
    parameter int SAMPLE_W  = 12,
    parameter int N_SUM     = 16,
    parameter int CLAMP_LIM = 14189
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IN_W-1:0]                       uniform_in,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [SAMPLE_W+$clog2(N_SUM):0]       out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready
);
    localparam int LOG2N = $clog2(N_SUM);
    localparam int ACC_W = SAMPLE_W + LOG2N;
    localparam int OUT_W = ACC_W + 1;

    localparam logic signed [OUT_W-1:0] OFFSET = OUT_W'(N_SUM * (2 ** (SAMPLE_W - 1)));
    localparam logic signed [OUT_W-1:0] LIM    = OUT_W'(CLAMP_LIM);
`ifdef CLT_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    typedef enum logic {ACCUM, STALL} state_t;

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     pend;
    logic [LOG2N-1:0]     cnt;
    logic [SAMPLE_W-1:0]  sample;
    logic [ACC_W-1:0]     sumNext;
    logic                 accept;
    logic                 lastSample;
    logic                 outXfer;
    logic                 slotFree;

    // Mean removal, then optional saturation; shared by the direct and pending load paths.
    function automatic logic signed [OUT_W-1:0] toResult(input logic [ACC_W-1:0] s);
        logic signed [OUT_W-1:0] r;
        r = $signed({1'b0, s}) - OFFSET;
        if (CLAMP_ON && (r > LIM))
            r = LIM;
        else if (CLAMP_ON && (r < -LIM))
            r = -LIM;
        return r;
    endfunction

    assign in_ready   = (state == ACCUM);
    assign sample     = uniform_in[IN_W-1 -: SAMPLE_W];
    assign sumNext    = acc + ACC_W'(sample);
    assign accept     = in_valid && in_ready;
    assign lastSample = (cnt == LOG2N'(N_SUM - 1));
    assign outXfer    = out_valid && out_ready;
    assign slotFree   = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            pend      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (outXfer)
                        out_valid <= 1'b0;
                    if (accept) begin
                        if (lastSample) begin
                            acc <= '0;
                            cnt <= '0;
                            if (slotFree) begin
                                out_data  <= toResult(sumNext);
                                out_valid <= 1'b1;
                            end else begin
                                pend  <= sumNext;
                                state <= STALL;
                            end
                        end else begin
                            acc <= sumNext;
                            cnt <= cnt + LOG2N'(1);
                        end
                    end
                end
                STALL: begin
                    // out_valid is always set here, so it simply stays high across the reload.
                    if (outXfer) begin
                        out_data <= toResult(pend);
                        state    <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
